// File: rtl/add_op_pipe_pkg.sv
// Shared types for the add_op_pipe_stage issue/retire slice.
// Optional flag storage is enabled by ADD_OP_PIPE_FLAGS_EN.
package add_op_pipe_pkg;

  localparam int ADD_OP_WIDTH = 32;
  localparam int ADD_OP_TAG_WIDTH = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int MAX_OCC = 3;

  typedef logic [1:0] occ_t;

  typedef struct packed {
    logic [ADD_OP_WIDTH-1:0] result;
    logic [ADD_OP_TAG_WIDTH-1:0] tag;
`ifdef ADD_OP_PIPE_FLAGS_EN
    logic carry;
    logic overflow;
`endif
  } add_op_entry_t;

  // Carry recovered from operand and result MSBs, no second adder.
  function automatic logic add_carry(
    input logic a,
    input logic b,
    input logic r
  );
    return (a & b) | ((a | b) & ~r);
  endfunction

  function automatic logic add_overflow(
    input logic a,
    input logic b,
    input logic r
  );
    return (a == b) && (r != a);
  endfunction

endpackage

// File: rtl/AddOp.sv
// AddOp core interface: operands in, wrapped sum out.
// Flag builds (ADD_OP_PIPE_FLAGS_EN) derive flags outside the core.
interface AddOp #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH-1:0] result;

  modport master (
    output lhs,
    output rhs,
    input result
  );

  modport impl (
    input lhs,
    input rhs,
    output result
  );

endinterface

// File: rtl/add_op_pipe_stage_if.sv
// Valid/ready operand and result channels of add_op_pipe_stage.
// Flag signals exist only with ADD_OP_PIPE_FLAGS_EN.
interface add_op_pipe_stage_if #(
  parameter int OPERAND_WIDTH = 32,
  parameter int TAG_WIDTH = 4
);

  logic in_valid;
  logic in_ready;
  logic [OPERAND_WIDTH-1:0] in_lhs;
  logic [OPERAND_WIDTH-1:0] in_rhs;
  logic [TAG_WIDTH-1:0] in_tag;

  logic out_valid;
  logic out_ready;
  logic [OPERAND_WIDTH-1:0] out_result;
  logic [TAG_WIDTH-1:0] out_tag;
`ifdef ADD_OP_PIPE_FLAGS_EN
  logic out_carry;
  logic out_overflow;
`endif

  modport master (
    output in_valid,
    input in_ready,
    output in_lhs,
    output in_rhs,
    output in_tag,
    input out_valid,
    output out_ready,
    input out_result,
`ifdef ADD_OP_PIPE_FLAGS_EN
    input out_carry,
    input out_overflow,
`endif
    input out_tag
  );

  modport slave (
    input in_valid,
    output in_ready,
    input in_lhs,
    input in_rhs,
    input in_tag,
    output out_valid,
    input out_ready,
    output out_result,
`ifdef ADD_OP_PIPE_FLAGS_EN
    output out_carry,
    output out_overflow,
`endif
    output out_tag
  );

endinterface

// File: rtl/AddOpImplNative.sv
// Native combinational AddOp implementation.
// Same in all builds, including ADD_OP_PIPE_FLAGS_EN.
module AddOpImplNative (
  AddOp.impl op
);

  assign op.result = op.lhs + op.rhs;

endmodule

// File: rtl/add_op_result_fifo.sv
// Two-entry result buffer with 1-bit wrapping pointers.
// Entry layout grows with ADD_OP_PIPE_FLAGS_EN via entry_t.
module add_op_result_fifo
  import add_op_pipe_pkg::*;
#(
  parameter type entry_t = add_op_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  entry_t din,
  output entry_t head,
  output logic [1:0] count
);

  entry_t mem [FIFO_DEPTH];
  logic wr_ptr;
  logic rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/add_op_pipe_stage.sv
// Issue/retire stage: operand register -> AddOp -> 2-entry result FIFO.
// ADD_OP_PIPE_FLAGS_EN adds carry/overflow outputs.
module add_op_pipe_stage
  import add_op_pipe_pkg::*;
#(
  parameter int OPERAND_WIDTH = ADD_OP_WIDTH,
  parameter int TAG_WIDTH = ADD_OP_TAG_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  add_op_pipe_stage_if.slave io
);

  localparam int MSB = OPERAND_WIDTH - 1;

  typedef struct packed {
    logic [OPERAND_WIDTH-1:0] result;
    logic [TAG_WIDTH-1:0] tag;
`ifdef ADD_OP_PIPE_FLAGS_EN
    logic carry;
    logic overflow;
`endif
  } entry_t;

  logic ready_q;
  logic s1_valid;
  logic [OPERAND_WIDTH-1:0] s1_lhs;
  logic [OPERAND_WIDTH-1:0] s1_rhs;
  logic [TAG_WIDTH-1:0] s1_tag;
  occ_t occ;
  logic [1:0] count;
  logic push_in;
  logic advance;
  logic pop;
  entry_t s1_entry;
  entry_t head;

  AddOp #(.WIDTH(OPERAND_WIDTH)) add_bus ();

  AddOpImplNative u_impl (
    .op(add_bus.impl)
  );

  assign add_bus.lhs = s1_lhs;
  assign add_bus.rhs = s1_rhs;

  assign push_in = io.in_valid && io.in_ready;
  // Advance looks only at the registered count; no out_ready path.
  assign advance = s1_valid && (count < 2'(FIFO_DEPTH));
  assign pop = io.out_valid && io.out_ready;

  assign io.in_ready = ready_q && (occ < 2'(MAX_OCC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      occ <= '0;
    end else begin
      ready_q <= 1'b1;
      occ <= occ + {1'b0, push_in} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lhs <= '0;
      s1_rhs <= '0;
      s1_tag <= '0;
    end else begin
      if (push_in) begin
        s1_valid <= 1'b1;
        s1_lhs <= io.in_lhs;
        s1_rhs <= io.in_rhs;
        s1_tag <= io.in_tag;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    s1_entry = '0;
    s1_entry.result = add_bus.result;
    s1_entry.tag = s1_tag;
`ifdef ADD_OP_PIPE_FLAGS_EN
    s1_entry.carry = add_carry(
      s1_lhs[MSB], s1_rhs[MSB], add_bus.result[MSB]);
    s1_entry.overflow = add_overflow(
      s1_lhs[MSB], s1_rhs[MSB], add_bus.result[MSB]);
`endif
  end

  add_op_result_fifo #(
    .entry_t(entry_t)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(advance),
    .pop(pop),
    .din(s1_entry),
    .head(head),
    .count(count)
  );

  assign io.out_valid = (count != 2'd0);
  assign io.out_result = head.result;
  assign io.out_tag = head.tag;
`ifdef ADD_OP_PIPE_FLAGS_EN
  assign io.out_carry = head.carry;
  assign io.out_overflow = head.overflow;
`endif

endmodule

// File: tb/tb_add_op_pipe_stage.sv
// Scoreboard bench for add_op_pipe_stage.
// Flag checks compile in with ADD_OP_PIPE_FLAGS_EN.
module tb_add_op_pipe_stage;
  import add_op_pipe_pkg::*;

  localparam int W = 32;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  add_op_pipe_stage_if #(.OPERAND_WIDTH(W), .TAG_WIDTH(T)) bus ();

  add_op_pipe_stage #(
    .OPERAND_WIDTH(W),
    .TAG_WIDTH(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(bus.slave)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [T-1:0] tag;
    logic c;
    logic ov;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int pops = 0;
  int stalls = 0;

  function automatic void check(
    input string name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic exp_t model(
    input logic [W-1:0] l,
    input logic [W-1:0] r,
    input logic [T-1:0] t
  );
    exp_t e;
    logic [W:0] s;
    s = {1'b0, l} + {1'b0, r};
    e.res = s[W-1:0];
    e.tag = t;
    e.c = s[W];
    e.ov = (l[W-1] == r[W-1]) && (s[W-1] != l[W-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got tag %0d expected none",
                 bus.out_tag);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_result", 64'(bus.out_result), 64'(e.res));
        check("out_tag", 64'(bus.out_tag), 64'(e.tag));
`ifdef ADD_OP_PIPE_FLAGS_EN
        check("out_carry", 64'(bus.out_carry), 64'(e.c));
        check("out_overflow", 64'(bus.out_overflow), 64'(e.ov));
`endif
        pops++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [W-1:0] l,
    input logic [W-1:0] r,
    input logic [T-1:0] t,
    input logic [W-1:0] er,
    input logic ec,
    input logic eo
  );
    int n;
    exp_t e;
    n = 0;
    bus.in_lhs = l;
    bus.in_rhs = r;
    bus.in_tag = t;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 (tag %0d)", t);
      bus.in_valid = 1'b0;
    end else begin
      e.res = er;
      e.tag = t;
      e.c = ec;
      e.ov = eo;
      q.push_back(e);
      stalls += n;
      step();
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check(name, 64'(q.size()), 64'd0);
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    exp_t e;
    logic [W-1:0] l;
    logic [W-1:0] r;

    bus.in_valid = 1'b0;
    bus.in_lhs = '0;
    bus.in_rhs = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_result", 64'(bus.out_result), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    #10;
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", 64'(bus.in_ready), 64'd0);
    step();
    check("in_ready_after_release", 64'(bus.in_ready), 64'd1);

    send(32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    check("valid_at_accept", 64'(bus.out_valid), 64'd0);
    step();
    check("valid_one_after", 64'(bus.out_valid), 64'd1);
    drain("single_drain");

    send(32'hFFFF_FFFF, 32'h0000_0002, 4'd5, 32'h0000_0001, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 4'd6, 32'h8000_0000, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 4'd7, 32'h0000_0000, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 32'h0000_0001, 4'd8, 32'h0000_0000, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    drain("arith_drain");

    bus.out_ready = 1'b0;
    p0 = pops;
    send(32'd100, 32'd1, 4'd1, 32'd101, 1'b0, 1'b0);
    send(32'd200, 32'd2, 4'd2, 32'd202, 1'b0, 1'b0);
    send(32'd300, 32'd3, 4'd3, 32'd303, 1'b0, 1'b0);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_lhs = 32'd400;
    bus.in_rhs = 32'd4;
    bus.in_tag = 4'd4;
    bus.in_valid = 1'b1;
    repeat (3) step();
    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    check("stall_out_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    send(32'd400, 32'd4, 4'd4, 32'd404, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    drain("bp_drain");
    check("bp_count", 64'(pops - p0), 64'd4);

    p0 = pops;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      l = $urandom;
      r = $urandom;
      e = model(l, r, 4'(i));
      send(l, r, 4'(i), e.res, e.c, e.ov);
    end
    bus.in_valid = 1'b0;
    check("stream_stalls", 64'(stalls), 64'd0);
    step();
    step();
    check("stream_tail", 64'(q.size()), 64'd0);
    q.delete();
    check("stream_count", 64'(pops - p0), 64'd100);

    bus.out_ready = 1'b0;
    send(32'd1, 32'd1, 4'd8, 32'd2, 1'b0, 1'b0);
    send(32'd2, 32'd2, 4'd9, 32'd4, 1'b0, 1'b0);
    send(32'd3, 32'd3, 4'd10, 32'd6, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    step();
    check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_out_result", 64'(bus.out_result), 64'd0);
    check("midrst_out_tag", 64'(bus.out_tag), 64'd0);
    q.delete();
    p0 = pops;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("post_rst_valid", 64'(bus.out_valid), 64'd0);
    check("post_rst_pops", 64'(pops - p0), 64'd0);
    send(32'd11, 32'd22, 4'd12, 32'd33, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    drain("post_rst_drain");
    check("post_rst_count", 64'(pops - p0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
